// File: rtl/is_uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART TX arbiter slice.
package is_uart_tx_arbiter_pkg;

  localparam int unsigned DATA_W          = 8;
  localparam int unsigned N_REQ_DEF       = 4;
  localparam int unsigned MAX_BURST_DEF   = 16;
  localparam int unsigned TIMEOUT_CYC_DEF = 2**20;

  typedef enum logic [1:0] {
    A_IDLE,
    A_LOAD,
    A_WAIT
  } arb_state_t;

endpackage

// File: rtl/is_uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after i_ptr, with wrap.
module is_uart_tx_arbiter_rr_pick
  import is_uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_grant,
  output logic                 o_any
);

  localparam int unsigned PTR_W = $clog2(N);

  logic [PTR_W-1:0] w_idx;

  // Scan i_ptr+1 .. i_ptr+N, keep the first hit.
  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_idx = PTR_W'((32'(i_ptr) + k) % N);
      if (!o_any && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/is_uart_tx_arbiter.sv
// Round-robin, burst-locked arbiter sharing one UART TX engine between N_REQ byte sources.
module is_uart_tx_arbiter #(
  parameter int unsigned N_REQ       = is_uart_tx_arbiter_pkg::N_REQ_DEF,
  parameter int unsigned DATA_W      = is_uart_tx_arbiter_pkg::DATA_W,
  parameter int unsigned MAX_BURST   = is_uart_tx_arbiter_pkg::MAX_BURST_DEF,
  parameter int unsigned TIMEOUT_CYC = is_uart_tx_arbiter_pkg::TIMEOUT_CYC_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  input  logic [N_REQ-1:0]        req_last_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    tx_req_o,
  output logic [DATA_W-1:0]       tx_data_o,
  input  logic                    tx_done_i,
  output logic                    busy_o,
  output logic                    timeout_o
);

  import is_uart_tx_arbiter_pkg::*;

  localparam int unsigned OWN_W   = $clog2(N_REQ);
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  localparam int unsigned WD_W    = $clog2(TIMEOUT_CYC);

  arb_state_t         r_state, w_state_nxt;
  logic [N_REQ-1:0]   r_grant, w_grant_nxt;
  logic [OWN_W-1:0]   r_owner, w_owner_nxt;
  logic [OWN_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [BURST_W-1:0] r_burst_cnt, w_burst_nxt;
  logic [WD_W-1:0]    r_wd_cnt, w_wd_nxt;
  logic               r_last, w_last_nxt;
  logic               r_tx_req, w_tx_req_nxt;
  logic [DATA_W-1:0]  r_tx_data, w_tx_data_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic               w_release;

  logic [N_REQ-1:0]   w_pick_grant;
  logic               w_pick_any;
  logic [OWN_W-1:0]   w_pick_idx;
  logic [DATA_W-1:0]  w_req_data [N_REQ];

  // Unpack the flat requester data bus into per-requester bytes.
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_req_data[g] = req_data_i[g*DATA_W +: DATA_W];
  end

  is_uart_tx_arbiter_rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .i_req   (req_valid_i),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_grant),
    .o_any   (w_pick_any)
  );

  // One-hot pick to owner index.
  always_comb begin
    w_pick_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_pick_grant[i]) w_pick_idx = OWN_W'(i);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_owner_nxt   = r_owner;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_burst_nxt   = r_burst_cnt;
    w_wd_nxt      = r_wd_cnt;
    w_last_nxt    = r_last;
    w_tx_req_nxt  = 1'b0;
    w_tx_data_nxt = r_tx_data;
    w_timeout_nxt = 1'b0;
    w_release     = 1'b0;

    unique case (r_state)
      A_IDLE: begin
        if (w_pick_any) begin
          w_grant_nxt = w_pick_grant;
          w_owner_nxt = w_pick_idx;
          w_burst_nxt = '0;
          w_state_nxt = A_LOAD;
        end
      end
      A_LOAD: begin
        if (req_valid_i[r_owner]) begin
          w_tx_data_nxt = w_req_data[r_owner];
          w_tx_req_nxt  = 1'b1;
          w_last_nxt    = req_last_i[r_owner];
          w_wd_nxt      = '0;
          w_state_nxt   = A_WAIT;
        end else begin
          w_release = 1'b1;
        end
      end
      A_WAIT: begin
        w_wd_nxt = (r_wd_cnt == '1) ? r_wd_cnt : r_wd_cnt + WD_W'(1);
        if (tx_done_i) begin
          w_burst_nxt = r_burst_cnt + BURST_W'(1);
          if (r_last || (w_burst_nxt == BURST_W'(MAX_BURST)) || !req_valid_i[r_owner]) begin
            w_release = 1'b1;
          end else begin
            w_state_nxt = A_LOAD;
          end
        end else if (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
          w_timeout_nxt = 1'b1;
          w_release     = 1'b1;
        end
      end
      default: w_state_nxt = A_IDLE;
    endcase

    // Releasing hands the lowest priority to the owner just served.
    if (w_release) begin
      w_grant_nxt  = '0;
      w_rr_ptr_nxt = r_owner;
      w_state_nxt  = A_IDLE;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= A_IDLE;
      r_grant     <= '0;
      r_owner     <= '0;
      r_rr_ptr    <= OWN_W'(N_REQ - 1);
      r_burst_cnt <= '0;
      r_wd_cnt    <= '0;
      r_last      <= 1'b0;
      r_tx_req    <= 1'b0;
      r_tx_data   <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_owner     <= w_owner_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_wd_cnt    <= w_wd_nxt;
      r_last      <= w_last_nxt;
      r_tx_req    <= w_tx_req_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign req_ready_o = {N_REQ{r_state == A_LOAD}} & r_grant & req_valid_i;
  assign grant_o     = r_grant;
  assign tx_req_o    = r_tx_req;
  assign tx_data_o   = r_tx_data;
  assign busy_o      = (r_state != A_IDLE);
  assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_is_uart_tx_arbiter.sv
// Self-checking bench: directed latency/reset/timeout steps plus random traffic vs. a queue-level model.
module tb_is_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int TO = 64;
  localparam int BUDGET = 5000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_last = '0;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  grant;
  logic          tx_req;
  logic [DW-1:0] tx_data;
  logic          tx_done = 1'b0;
  logic          busy;
  logic          timeout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] mem_d [N][32];
  bit         mem_l [N][32];
  int         head  [N];
  int         tail  [N];
  int         m_ptr;
  int         exp_src [$];
  int         exp_dat [$];

  is_uart_tx_arbiter #(
    .N_REQ       (N),
    .DATA_W      (DW),
    .MAX_BURST   (MB),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .grant_o     (grant),
    .tx_req_o    (tx_req),
    .tx_data_o   (tx_data),
    .tx_done_i   (tx_done),
    .busy_o      (busy),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic clear_q();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input bit l);
    mem_d[i][tail[i]] = d;
    mem_l[i][tail[i]] = l;
    tail[i]++;
  endtask

  function automatic bit q_empty();
    for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_q();
    for (int i = 0; i < N; i++) begin
      if (head[i] < tail[i]) begin
        req_valid[i]         = 1'b1;
        req_data[i*DW +: DW] = mem_d[i][head[i]];
        req_last[i]          = mem_l[i][head[i]];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_last[i]          = 1'b0;
      end
    end
  endtask

  // Reference: predicted transmit order from the queue contents and fairness rules.
  task automatic build_expect(input int to_idx);
    int  h [N];
    int  owner;
    int  n;
    bit  stop;
    exp_src.delete();
    exp_dat.delete();
    for (int i = 0; i < N; i++) h[i] = head[i];
    forever begin
      owner = -1;
      for (int k = 1; k <= N; k++) begin
        if (owner < 0 && h[(m_ptr + k) % N] < tail[(m_ptr + k) % N]) owner = (m_ptr + k) % N;
      end
      if (owner < 0) break;
      n = 0;
      stop = 1'b0;
      while (!stop) begin
        exp_src.push_back(owner);
        exp_dat.push_back(int'(mem_d[owner][h[owner]]));
        stop = mem_l[owner][h[owner]];
        h[owner]++;
        n++;
        if (n == MB || h[owner] == tail[owner] || (exp_src.size() - 1) == to_idx) stop = 1'b1;
      end
      m_ptr = owner;
    end
  endtask

  // Acts as requesters and TX engine; frame number to_idx is never completed.
  task automatic run_traffic(input string name, input int to_idx);
    int n, cd, pop, to_due, src;
    logic [7:0] cur_byte;
    bit ended;
    build_expect(to_idx);
    n = 0; cd = 0; pop = -1; to_due = -1; ended = 1'b0; cur_byte = '0;
    drive_q();
    for (int g = 0; g < BUDGET && !ended; g++) begin
      tick();
      if (pop >= 0) begin
        head[pop]++;
        pop = -1;
      end
      drive_q();
      if (cd > 0) begin
        cd--;
        tx_done = (cd == 0);
      end else begin
        tx_done = 1'b0;
      end
      #1;
      if (req_ready != '0) begin
        chk({name, "/ready_owner"}, 32'(req_ready), 32'(grant));
        pop = oh_idx(req_ready);
      end
      if (tx_req) begin
        src = oh_idx(grant);
        chk({name, "/grant_onehot"}, 32'($onehot(grant)), 32'd1);
        if (n < exp_src.size()) begin
          chk({name, "/src"}, 32'(src), 32'(exp_src[n]));
          chk({name, "/data"}, 32'(tx_data), 32'(exp_dat[n]));
        end else begin
          chk({name, "/extra_frame"}, 32'(n), 32'(exp_src.size()));
        end
        cur_byte = tx_data;
        if (n == to_idx) to_due = cyc + TO;
        else cd = $urandom_range(1, 8);
        n++;
      end else if (cd > 0) begin
        chk({name, "/data_stable"}, 32'(tx_data), 32'(cur_byte));
      end
      if (timeout || cyc == to_due) chk({name, "/timeout_at"}, {30'd0, timeout, cyc == to_due}, 32'd3);
      if (n == exp_src.size() && cd == 0 && !busy && q_empty() && cyc > to_due) ended = 1'b1;
    end
    tx_done = 1'b0;
    chk({name, "/finished"}, 32'(ended), 32'd1);
    chk({name, "/frames"}, 32'(n), 32'(exp_src.size()));
    chk({name, "/idle_grant"}, 32'(grant), 32'd0);
  endtask

  initial begin
    int c0;
    clear_q();
    m_ptr = N - 1;

    // Reset values.
    tick();
    tick();
    chk("rst/grant", 32'(grant), 32'd0);
    chk("rst/tx_req", 32'(tx_req), 32'd0);
    chk("rst/tx_data", 32'(tx_data), 32'd0);
    chk("rst/timeout", 32'(timeout), 32'd0);
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    tick();

    // Single byte: latency of grant, ready, strobe and release.
    req_valid = 4'b0001;
    req_data  = 32'h0000_00A5;
    req_last  = 4'b0001;
    c0 = cyc;
    #1;
    chk("single/ready_idle", 32'(req_ready), 32'd0);
    tick();
    chk("single/grant_c1", 32'(grant), 32'd1);
    chk("single/ready_c1", 32'(req_ready), 32'd1);
    chk("single/busy_c1", 32'(busy), 32'd1);
    tick();
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    chk("single/tx_req_c2", 32'(tx_req), 32'd1);
    chk("single/tx_data_c2", 32'(tx_data), 32'hA5);
    tick();
    chk("single/tx_req_c3", 32'(tx_req), 32'd0);
    while (cyc < c0 + 20) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("single/grant_c21", 32'(grant), 32'd0);
    chk("single/busy_c21", 32'(busy), 32'd0);
    m_ptr = 0;
    // Stray done while idle must not start anything.
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("idle_done/busy", 32'(busy), 32'd0);
    chk("idle_done/grant", 32'(grant), 32'd0);

    // Watchdog: first frame is never completed.
    clear_q();
    push(1, 8'h11, 1'b0);
    push(1, 8'h12, 1'b1);
    push(2, 8'h21, 1'b1);
    run_traffic("watchdog", 0);

    // Contention: one byte each from 0,1,2, then 0 again.
    clear_q();
    push(0, 8'h01, 1'b1);
    push(1, 8'h02, 1'b1);
    push(2, 8'h03, 1'b1);
    push(0, 8'h04, 1'b1);
    run_traffic("contention", -1);

    // Burst lock against a waiting requester.
    clear_q();
    for (int j = 0; j < 5; j++) push(1, 8'(8'h30 + j), j == 4);
    push(3, 8'h77, 1'b0);
    push(3, 8'h78, 1'b1);
    run_traffic("burst_lock", -1);

    // Burst cap with no last flags.
    clear_q();
    for (int j = 0; j < 10; j++) push(2, 8'(8'h40 + j), 1'b0);
    for (int j = 0; j < 6; j++) push(0, 8'(8'h90 + j), 1'b0);
    run_traffic("burst_cap", -1);

    // Random traffic rounds.
    for (int r = 0; r < 4; r++) begin
      clear_q();
      for (int i = 0; i < N; i++) begin
        int len;
        len = $urandom_range(0, 10);
        for (int j = 0; j < len; j++) push(i, 8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
      end
      run_traffic("random", -1);
    end

    // Reset in the middle of a frame.
    clear_q();
    req_valid = 4'b0100;
    req_data  = 32'h003C_0000;
    req_last  = 4'b0100;
    tick();
    chk("midrst/grant", 32'(grant), 32'h4);
    tick();
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    chk("midrst/tx_req", 32'(tx_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst/grant_async", 32'(grant), 32'd0);
    chk("midrst/tx_req_async", 32'(tx_req), 32'd0);
    chk("midrst/busy_async", 32'(busy), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    m_ptr = N - 1;
    push(2, 8'h6B, 1'b1);
    push(0, 8'h5A, 1'b1);
    run_traffic("post_reset", -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
